cache_sa2_wb: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU load/store port and a line-wide memory port.
- Next generation of the team's direct-mapped cache:
  - configurable set count, line size and widths
  - per-set LRU replacement
  - registered CPU request/response handshake
  - explicit flush operation that writes back all dirty lines.

---
 rtl/cache_sa2_wb.sv | 217 +++++++++++++++++++++
 tb/tb_cache_sa2_wb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sa2_wb.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU
// replacement and an explicit flush that writes back every dirty line.
module cache_sa2_wb #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 4,
  localparam int unsigned LINE_W = DATA_W * WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned SCAN_W = IDX_W + 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOOKUP     = 3'd1;
  localparam logic [2:0] WRITEBACK  = 3'd2;
  localparam logic [2:0] ALLOCATE   = 3'd3;
  localparam logic [2:0] FLUSH_SCAN = 3'd4;
  localparam logic [2:0] FLUSH_WB   = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [DATA_W-1:0] req_wdata;

  logic [LINE_W-1:0] data_arr  [2][SETS];
  logic [TAG_W-1:0]  tag_arr   [2][SETS];
  logic [SETS-1:0]   valid_arr [2];
  logic [SETS-1:0]   dirty_arr [2];
  logic [SETS-1:0]   lru;          // way to evict next in each set

  logic              victim;
  logic [SCAN_W-1:0] scan;
  logic              mem_valid;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              done;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  int unsigned       word_lsb;
  logic              hit0, hit1, hit, hit_way, miss_way, miss_dirty;
  logic [IDX_W-1:0]  scan_set;
  logic              scan_way, scan_dirty, scan_last, mem_ack;

  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_off    = req_addr[OFF_W-1:0];
  assign word_lsb   = 32'(req_off) * DATA_W;

  assign hit0       = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
  assign hit1       = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
  assign hit        = hit0 | hit1;
  assign hit_way    = !hit0;
  // First invalid way wins, otherwise fall back to the LRU way.
  assign miss_way   = !valid_arr[0][req_idx] ? 1'b0 :
                      !valid_arr[1][req_idx] ? 1'b1 : lru[req_idx];
  assign miss_dirty = valid_arr[miss_way][req_idx] & dirty_arr[miss_way][req_idx];

  assign scan_set   = scan[SCAN_W-1:1];
  assign scan_way   = scan[0];
  assign scan_dirty = valid_arr[scan_way][scan_set] & dirty_arr[scan_way][scan_set];
  assign scan_last  = (scan == SCAN_W'(SETS * 2 - 1));
  assign mem_ack    = mem_valid & mem_ready;

  assign cpu_req_ready  = !rst && (state == IDLE) && !flush_req;
  assign cpu_resp_valid = resp_valid;
  assign cpu_resp_rdata = resp_rdata;
  assign flush_done     = done;
  assign mem_req_valid  = mem_valid;

  always_comb begin
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (mem_valid) begin
      case (state)
        WRITEBACK: begin
          mem_req_rw    = 1'b1;
          mem_req_addr  = {tag_arr[victim][req_idx], req_idx, {OFF_W{1'b0}}};
          mem_req_wdata = data_arr[victim][req_idx];
        end
        ALLOCATE: begin
          mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
        FLUSH_WB: begin
          mem_req_rw    = 1'b1;
          mem_req_addr  = {tag_arr[scan_way][scan_set], scan_set, {OFF_W{1'b0}}};
          mem_req_wdata = data_arr[scan_way][scan_set];
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits guard its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ALLOCATE && mem_ack) begin
        data_arr[victim][req_idx] <= mem_rdata;
        tag_arr[victim][req_idx]  <= req_tag;
      end else if (state == LOOKUP && hit && req_rw) begin
        data_arr[hit_way][req_idx][word_lsb +: DATA_W] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_rw       <= 1'b0;
      req_wdata    <= '0;
      valid_arr[0] <= '0;
      valid_arr[1] <= '0;
      dirty_arr[0] <= '0;
      dirty_arr[1] <= '0;
      lru          <= '0;
      victim       <= 1'b0;
      scan         <= '0;
      mem_valid    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      done         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            scan  <= '0;
            state <= FLUSH_SCAN;
          end else if (cpu_req_valid) begin
            req_addr  <= cpu_req_addr;
            req_rw    <= cpu_req_rw;
            req_wdata <= cpu_req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid   <= 1'b1;
            lru[req_idx] <= ~hit_way;
            state        <= IDLE;
            if (req_rw) dirty_arr[hit_way][req_idx] <= 1'b1;
            else        resp_rdata <= data_arr[hit_way][req_idx][word_lsb +: DATA_W];
          end else begin
            victim <= miss_way;
            state  <= miss_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
          end else if (mem_ready) begin
            mem_valid                  <= 1'b0;
            dirty_arr[victim][req_idx] <= 1'b0;
            state                      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
          end else if (mem_ready) begin
            mem_valid                  <= 1'b0;
            valid_arr[victim][req_idx] <= 1'b1;
            dirty_arr[victim][req_idx] <= 1'b0;
            state                      <= LOOKUP;
          end
        end
        FLUSH_SCAN: begin
          if (scan_dirty) begin
            state <= FLUSH_WB;
          end else if (scan_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            scan <= scan + 1'b1;
          end
        end
        FLUSH_WB: begin
          // Return to the same entry; it is now clean so the scan moves on.
          if (!mem_valid) begin
            mem_valid <= 1'b1;
          end else if (mem_ready) begin
            mem_valid                       <= 1'b0;
            dirty_arr[scan_way][scan_set]   <= 1'b0;
            state                           <= FLUSH_SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa2_wb.sv
// Directed bench for cache_sa2_wb: flat-memory reference, response scoreboard and a
// memory responder that logs every line request and checks field stability.
module tb_cache_sa2_wb;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int SETS   = 4;
  localparam int LINE_W = DATA_W * WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_rw;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_resp_rdata;
  logic              flush_req, flush_done;
  logic              mem_req_valid, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  cache_sa2_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic rw; logic [DATA_W-1:0] data;} exp_t;
  typedef struct packed {logic rw; logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] wdata;} mreq_t;

  exp_t              exp_q[$];
  mreq_t             log_q[$];
  logic [DATA_W-1:0] ref_mem [256];
  logic [LINE_W-1:0] mem [64];
  logic [DATA_W-1:0] last_rd;
  int                checks = 0;
  int                errors = 0;
  int                mem_delay = 0;
  int                done_cnt = 0;

  function automatic logic [DATA_W-1:0] word_init(input int a);
    if (a >= 8'h14 && a <= 8'h17) return 32'h11111111 * 32'(a - 8'h14 + 1);
    return 32'hA5000000 | 32'(a);
  endfunction

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (flush_done) done_cnt++;

  // Memory responder: answers mem_delay cycles after a request is first seen.
  initial begin
    logic        active;
    mreq_t       cap;
    int          waited;
    active = 1'b0;
    waited = 0;
    cap    = '0;
    for (int i = 0; i < 64; i++)
      mem[i] = {word_init(4*i+3), word_init(4*i+2), word_init(4*i+1), word_init(4*i)};
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!mem_req_valid || rst) begin
        active = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        waited = 0;
        cap    = '{rw: mem_req_rw, addr: mem_req_addr, wdata: mem_req_wdata};
        log_q.push_back(cap);
      end else begin
        check("mem_rw_stable", LINE_W'(mem_req_rw), LINE_W'(cap.rw));
        check("mem_addr_stable", LINE_W'(mem_req_addr), LINE_W'(cap.addr));
        check("mem_wdata_stable", mem_req_wdata, cap.wdata);
      end
      if (active) begin
        if (waited >= mem_delay) begin
          mem_ready = 1'b1;
          if (cap.rw) mem[cap.addr[7:2]] = cap.wdata;
          else        mem_rdata = mem[cap.addr[7:2]];
          active = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic cpu_op(input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    n = 0;
    while (!cpu_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_req_ready) begin
      check("ready_timeout", 0, 1);
      cpu_req_valid = 1'b0;
      lat = -1;
      return;
    end
    if (rw) begin
      ref_mem[addr] = wd;
      e = '{rw: 1'b1, data: last_rd};
    end else begin
      last_rd = ref_mem[addr];
      e = '{rw: 1'b0, data: last_rd};
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    n = 0;
    while (!cpu_resp_valid && n < 300) begin
      @(negedge clk);
      lat++;
      n++;
    end
    if (!cpu_resp_valid) begin
      check("resp_timeout", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("rdata@%0h", addr), LINE_W'(cpu_resp_rdata), LINE_W'(e.data));
    end
  endtask

  task automatic do_flush(output int cyc);
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    cyc = 0;
    while (!flush_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_done", LINE_W'(flush_done), 1);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mem_valid", LINE_W'(mem_req_valid), 0);
    check("rst_ready", LINE_W'(cpu_req_ready), 0);
    check("rst_resp_valid", LINE_W'(cpu_resp_valid), 0);
    check("rst_flush_done", LINE_W'(flush_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    #1;
    check("post_rst_ready", LINE_W'(cpu_req_ready), 1);
    check("post_rst_rdata", LINE_W'(cpu_resp_rdata), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, d0, n;
    for (int i = 0; i < 256; i++) ref_mem[i] = word_init(i);
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_rw = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    flush_req = 1'b0;
    last_rd = '0;
    apply_reset();

    // Cold miss fill, then a hit in the same line.
    log_q.delete();
    cpu_op(1'b0, 8'h14, '0, lat);
    check("fill_count", LINE_W'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      check("fill_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h14));
      check("fill_rw", LINE_W'(log_q[0].rw), 0);
    end
    log_q.delete();
    cpu_op(1'b0, 8'h15, '0, lat);
    check("hit_latency", LINE_W'(lat), 2);
    check("hit_no_mem", LINE_W'(log_q.size()), 0);

    // Clean LRU eviction.
    cpu_op(1'b0, 8'h24, '0, lat);
    cpu_op(1'b0, 8'h14, '0, lat);
    log_q.delete();
    cpu_op(1'b0, 8'h34, '0, lat);
    check("clean_evict_count", LINE_W'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      check("clean_evict_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h34));
      check("clean_evict_rw", LINE_W'(log_q[0].rw), 0);
    end
    log_q.delete();
    cpu_op(1'b0, 8'h14, '0, lat);
    check("lru_keep_hit", LINE_W'(lat), 2);
    check("lru_keep_no_mem", LINE_W'(log_q.size()), 0);

    // Dirty eviction.
    cpu_op(1'b1, 8'h16, 32'hDEADBEEF, lat);
    check("write_hit_latency", LINE_W'(lat), 2);
    cpu_op(1'b0, 8'h24, '0, lat);
    log_q.delete();
    cpu_op(1'b0, 8'h34, '0, lat);
    check("wb_count", LINE_W'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      check("wb_rw", LINE_W'(log_q[0].rw), 1);
      check("wb_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h14));
      check("wb_word2", LINE_W'(log_q[0].wdata[95:64]), LINE_W'(32'hDEADBEEF));
      check("wb_refill_rw", LINE_W'(log_q[1].rw), 0);
      check("wb_refill_addr", LINE_W'(log_q[1].addr), LINE_W'(8'h34));
    end
    cpu_op(1'b0, 8'h16, '0, lat);

    // Flush with dirty lines in sets 0 and 3, then an empty flush.
    cpu_op(1'b1, 8'h40, 32'h1111AAAA, lat);
    cpu_op(1'b1, 8'h5C, 32'h2222BBBB, lat);
    log_q.delete();
    d0 = done_cnt;
    do_flush(cyc);
    check("flush_wb_count", LINE_W'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      check("flush_wb0_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h40));
      check("flush_wb0_data", LINE_W'(log_q[0].wdata[31:0]), LINE_W'(32'h1111AAAA));
      check("flush_wb1_addr", LINE_W'(log_q[1].addr), LINE_W'(8'h5C));
      check("flush_wb1_rw", LINE_W'(log_q[1].rw), 1);
    end
    @(negedge clk);
    check("flush_done_pulses", LINE_W'(done_cnt - d0), 1);
    log_q.delete();
    do_flush(cyc);
    check("flush2_cycles", LINE_W'(cyc), 8);
    check("flush2_no_wb", LINE_W'(log_q.size()), 0);
    cpu_op(1'b0, 8'h40, '0, lat);
    check("post_flush_hit", LINE_W'(lat), 2);

    // Slow memory, then reset during an allocate.
    mem_delay = 5;
    cpu_op(1'b0, 8'h80, '0, lat);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 8'h90;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("alloc_started", LINE_W'(mem_req_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_drops_mem_valid", LINE_W'(mem_req_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    mem_delay = 0;
    log_q.delete();
    cpu_op(1'b0, 8'h90, '0, lat);
    check("post_rst_miss", LINE_W'(log_q.size()), 1);
    if (log_q.size() > 0) check("post_rst_miss_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h90));

    // Flush and request together: flush wins, request follows.
    cpu_op(1'b1, 8'h01, 32'h12345678, lat);
    log_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    flush_req     = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 8'h01;
    #1;
    check("ready_low_on_flush", LINE_W'(cpu_req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    flush_req     = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_op(1'b0, 8'h01, '0, lat);
    check("flush_first_done", LINE_W'(done_cnt - d0), 1);
    check("flush_first_wb", LINE_W'(log_q.size()), 1);
    if (log_q.size() > 0) check("flush_first_addr", LINE_W'(log_q[0].addr), LINE_W'(8'h00));
    check("after_flush_hit", LINE_W'(lat), 2);

    check("scoreboard_empty", LINE_W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
